// File: rtl/conv_window_sequencer_if.sv
// Bundle between the window sequencer and its environment: start request,
// MAC result return, window anchors and the packed output map.
interface conv_window_sequencer_if #(
    parameter int data_width     = 16,
    parameter int output_channel = 1,
    parameter int result_length  = 2,
    parameter int result_width   = 2
);
    localparam int RES_BITS = output_channel * result_length * result_width * data_width;

    logic                                 conv_en;
    logic                                 res_valid;
    logic [output_channel*data_width-1:0] res_data;
    logic [data_width-1:0]                archor_1D;
    logic [data_width-1:0]                archor_2D;
    logic                                 win_valid;
    logic                                 busy;
    logic                                 done;
    logic [0:RES_BITS-1]                  result;

    modport master (
        input  conv_en, res_valid, res_data,
        output archor_1D, archor_2D, win_valid, busy, done, result
    );

    modport slave (
        output conv_en, res_valid, res_data,
        input  archor_1D, archor_2D, win_valid, busy, done, result
    );
endinterface

// File: rtl/conv_window_sequencer.sv
// Walks output positions row-major, issues one anchor window at a time to
// convBuffer and packs each returned MAC result into the output feature map.
module conv_window_sequencer #(
    parameter int data_width     = 16,
    parameter int output_channel = 1,
    parameter int result_length  = 2,
    parameter int result_width   = 2,
    parameter int stride         = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    conv_window_sequencer_if.master bus
);
    localparam int SLOTS    = result_length * result_width;
    localparam int RES_BITS = output_channel * SLOTS * data_width;
    localparam int RL       = (result_length > 1) ? $clog2(result_length) : 1;
    localparam int RW       = (result_width  > 1) ? $clog2(result_width)  : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                state;
    logic [RL-1:0]         r;
    logic [RW-1:0]         c;
    logic [data_width-1:0] archor_1D;
    logic [data_width-1:0] archor_2D;
    logic                  win_valid;
    logic                  busy;
    logic                  done;
    logic [0:RES_BITS-1]   result;

    assign bus.archor_1D = archor_1D;
    assign bus.archor_2D = archor_2D;
    assign bus.win_valid = win_valid;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.result    = result;

    // Anchors advance by stride alongside the counters, so they always equal
    // counter*stride truncated to data_width without a multiplier.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            r         <= '0;
            c         <= '0;
            archor_1D <= '0;
            archor_2D <= '0;
            win_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
        end else begin
            win_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.conv_en) begin
                        result    <= '0;
                        r         <= '0;
                        c         <= '0;
                        archor_1D <= '0;
                        archor_2D <= '0;
                        win_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (bus.res_valid) begin
                        for (int rr = 0; rr < result_length; rr++)
                            for (int cc = 0; cc < result_width; cc++)
                                if (r == RL'(rr) && c == RW'(cc))
                                    for (int ch = 0; ch < output_channel; ch++)
                                        result[(ch*SLOTS + rr*result_width + cc)*data_width +: data_width]
                                            <= bus.res_data[(output_channel-1-ch)*data_width +: data_width];
                        if (c != RW'(result_width - 1)) begin
                            c         <= c + 1'b1;
                            archor_1D <= archor_1D + data_width'(stride);
                            win_valid <= 1'b1;
                            state     <= ISSUE;
                        end else if (r != RL'(result_length - 1)) begin
                            c         <= '0;
                            r         <= r + 1'b1;
                            archor_1D <= '0;
                            archor_2D <= archor_2D + data_width'(stride);
                            win_valid <= 1'b1;
                            state     <= ISSUE;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_window_sequencer.sv
// Scoreboard bench: three sequencer configurations, randomized result latency
// and data, checked against an arithmetic model of the scan order and map layout.
module tb_conv_window_sequencer;
    localparam int NI   = 3;
    localparam int MAXB = 192;
    localparam int CW   = 200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     reset;
    logic [NI-1:0]            conv_en, res_valid, win_valid, busy, done;
    logic [NI-1:0][31:0]      rdata;
    logic [NI-1:0][15:0]      a1, a2;
    logic [NI-1:0][MAXB-1:0]  res_w;

    int och [NI] = '{1, 1, 2};
    int rl  [NI] = '{2, 2, 2};
    int rw  [NI] = '{2, 2, 3};
    int st  [NI] = '{1, 2, 3};
    logic [15:0] tbl [4] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};

    conv_window_sequencer_if #(.data_width(16)) b0 ();
    conv_window_sequencer_if #(.data_width(16)) b1 ();
    conv_window_sequencer_if #(.data_width(16), .output_channel(2), .result_length(2), .result_width(3)) b2 ();

    conv_window_sequencer u0 (.clk(clk), .reset(reset), .bus(b0));
    conv_window_sequencer #(.stride(2)) u1 (.clk(clk), .reset(reset), .bus(b1));
    conv_window_sequencer #(.output_channel(2), .result_length(2), .result_width(3), .stride(3))
        u2 (.clk(clk), .reset(reset), .bus(b2));

    assign b0.conv_en = conv_en[0]; assign b0.res_valid = res_valid[0]; assign b0.res_data = rdata[0][15:0];
    assign b1.conv_en = conv_en[1]; assign b1.res_valid = res_valid[1]; assign b1.res_data = rdata[1][15:0];
    assign b2.conv_en = conv_en[2]; assign b2.res_valid = res_valid[2]; assign b2.res_data = rdata[2];
    assign win_valid = {b2.win_valid, b1.win_valid, b0.win_valid};
    assign busy      = {b2.busy, b1.busy, b0.busy};
    assign done      = {b2.done, b1.done, b0.done};
    assign a1[0] = b0.archor_1D; assign a1[1] = b1.archor_1D; assign a1[2] = b2.archor_1D;
    assign a2[0] = b0.archor_2D; assign a2[1] = b1.archor_2D; assign a2[2] = b2.archor_2D;
    assign res_w[0] = MAXB'(b0.result);
    assign res_w[1] = MAXB'(b1.result);
    assign res_w[2] = MAXB'(b2.result);

    logic [33:0]     anc_q [$];
    logic [MAXB+1:0] res_q [$];
    logic [MAXB-1:0] last_map [NI];
    int n_done [NI];
    int n_chk, n_fail;
    bit stop;

    function automatic void chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chkb(input string name, input logic act, input logic exp);
        chk(name, CW'(act), CW'(exp));
    endfunction

    task automatic wait_win(input int i, output bit ok);
        int n = 0;
        while (win_valid[i] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = (win_valid[i] === 1'b1);
        chkb("win_valid_timeout", ok, 1'b1);
    endtask

    // mode 0: random data, 1: constant per-config data, 2: 3C00/4000/4200/4400 table
    task automatic scan(input int i, input int mode, input bit edges, input int nscans);
        logic [15:0]     model [2][6];
        logic [MAXB-1:0] exp;
        logic [31:0]     d;
        bit              ok;
        int              done0, slots;
        done0 = n_done[i];
        slots = rl[i] * rw[i];
        exp   = '0;
        for (int s = 0; s < nscans; s++) begin
            for (int r = 0; r < rl[i]; r++)
                for (int c = 0; c < rw[i]; c++)
                    anc_q.push_back({2'(i), 16'(r*st[i]), 16'(c*st[i])});
            if (s == 0) conv_en[i] = 1'b1;
            @(negedge clk);
            if (s > 0) chkb("b2b_single_idle_gap", win_valid[i], 1'b1);
            for (int k = 0; k < slots; k++) begin
                wait_win(i, ok);
                if (!ok) return;
                conv_en[i]   = (nscans > 1) ? 1'b1 : (edges ? 1'($urandom_range(0, 1)) : 1'b0);
                res_valid[i] = edges;
                rdata[i]     = $urandom;
                @(negedge clk);
                res_valid[i] = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                d = (mode == 0) ? $urandom :
                    (mode == 1) ? ((och[i] == 1) ? 32'h0000_4400 : 32'h3C00_4000) : {16'h0, tbl[k%4]};
                res_valid[i] = 1'b1;
                rdata[i]     = d;
                for (int ch = 0; ch < och[i]; ch++)
                    model[ch][k] = d[(och[i]-1-ch)*16 +: 16];
                if (k == slots - 1) begin
                    exp = '0;
                    for (int ch = 0; ch < och[i]; ch++)
                        for (int kk = 0; kk < slots; kk++)
                            exp = (exp << 16) | MAXB'(model[ch][kk]);
                    res_q.push_back({2'(i), exp});
                end
                @(negedge clk);
                res_valid[i] = 1'b0;
            end
            chkb("done_pulse", done[i], 1'b1);
            conv_en[i] = edges | (s < nscans - 1);
            @(negedge clk);
            chkb("idle_win_valid", win_valid[i], 1'b0);
            chkb("idle_busy", busy[i], 1'b0);
            chk("result_after_done", CW'(res_w[i]), CW'(exp));
            last_map[i] = exp;
            conv_en[i]  = (s < nscans - 1);
        end
        chk("done_count", CW'(n_done[i] - done0), CW'(nscans));
    endtask

    task automatic idle_noise(input int i);
        for (int n = 0; n < 3; n++) begin
            res_valid[i] = 1'b1;
            rdata[i]     = $urandom;
            @(negedge clk);
        end
        res_valid[i] = 1'b0;
        chk("idle_result_hold", CW'(res_w[i]), CW'(last_map[i]));
        chkb("idle_no_window", win_valid[i], 1'b0);
    endtask

    initial begin
        bit ok;
        n_chk = 0; n_fail = 0; stop = 1'b0;
        reset = 1'b1; conv_en = '0; res_valid = '0; rdata = '0;
        for (int i = 0; i < NI; i++) begin n_done[i] = 0; last_map[i] = '0; end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NI; i++) begin
            chk("reset_result", CW'(res_w[i]), '0);
            chk("reset_anchors", CW'({a2[i], a1[i]}), '0);
            chk("reset_flags", CW'({win_valid[i], busy[i], done[i]}), '0);
        end
        fork
            begin
                scan(0, 1, 1'b0, 1);
                chk("map_default_4400", CW'(res_w[0]), CW'(64'h4400_4400_4400_4400));
                scan(1, 2, 1'b0, 1);
                chk("map_stride2_table", CW'(res_w[1]), CW'(64'h3C00_4000_4200_4400));
                scan(2, 1, 1'b0, 1);
                chk("map_two_channel", CW'(res_w[2]), CW'({{6{16'h3C00}}, {6{16'h4000}}}));
                idle_noise(0);
                scan(0, 0, 1'b1, 1);
                idle_noise(0);
                // abort during the WAIT of the second window
                anc_q.push_back({2'd0, 16'd0, 16'd0});
                anc_q.push_back({2'd0, 16'd0, 16'd1});
                conv_en[0] = 1'b1;
                @(negedge clk);
                conv_en[0] = 1'b0;
                wait_win(0, ok);
                @(negedge clk);
                res_valid[0] = 1'b1; rdata[0] = 32'h1234;
                @(negedge clk);
                res_valid[0] = 1'b0;
                wait_win(0, ok);
                @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                for (int i = 0; i < NI; i++) last_map[i] = '0;
                chk("abort_result", CW'(res_w[0]), '0);
                chk("abort_anchors", CW'({a2[0], a1[0]}), '0);
                chk("abort_flags", CW'({win_valid[0], busy[0], done[0]}), '0);
                chkb("abort_windows_seen", anc_q.size() == 0, 1'b1);
                scan(0, 1, 1'b0, 1);
                scan(0, 0, 1'b0, 2);
                scan(2, 0, 1'b1, 2);
                for (int n = 0; n < 6; n++) scan(n % NI, 0, 1'b1, 1);
                repeat (5) @(negedge clk);
                chkb("anchor_queue_drained", anc_q.size() == 0, 1'b1);
                chkb("result_queue_drained", res_q.size() == 0, 1'b1);
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    @(negedge clk);
                    for (int i = 0; i < NI; i++) begin
                        if (win_valid[i]) begin
                            chkb("busy_in_issue", busy[i], 1'b1);
                            chkb("window_expected", anc_q.size() != 0, 1'b1);
                            if (anc_q.size() != 0)
                                chk("anchor", CW'({2'(i), a2[i], a1[i]}), CW'(anc_q.pop_front()));
                        end
                        if (done[i]) begin
                            n_done[i]++;
                            chkb("busy_at_done", busy[i], 1'b0);
                            chkb("done_expected", res_q.size() != 0, 1'b1);
                            if (res_q.size() != 0)
                                chk("result_map", CW'({2'(i), res_w[i]}), CW'(res_q.pop_front()));
                        end
                    end
                end
            end
        join
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/conv_window_sequencer.md
Name: conv_window_sequencer

Overview:
- Drives the anchor side of `convBuffer` and collects per-window convolution results into a packed output feature map.
- Walks every output position in row-major order and presents the input-image anchor (`archor_2D` = row, `archor_1D` = column) for each window.
- Waits for the downstream float16 MAC result, then writes it into the correct slot of `result`.
- Sits between `convBuffer`/MAC and the next layer; it is the writer/controller counterpart to the buffer's window reader.

Parameters:
- `data_width`, 16, bits per float16 element and width of each anchor.
- `output_channel`, 1, number of result channels delivered per window.
- `result_length`, 2, output rows.
- `result_width`, 2, output columns.
- `stride`, 1, anchor step in input pixels per output step.

Ports:
- `clk`  input  1  system clock, all logic on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `conv_en`  input  1  start request; sampled only in IDLE.
- `res_valid`  input  1  `res_data` is valid this cycle.
- `res_data`  input  `output_channel*data_width`  one float16 per channel; channel 0 in the MSBs.
- `archor_1D`  output  `data_width`  column anchor = c*`stride`.
- `archor_2D`  output  `data_width`  row anchor = r*`stride`.
- `win_valid`  output  1  one-cycle pulse: anchors are fresh and the window should be computed.
- `busy`  output  1  high in ISSUE and WAIT.
- `done`  output  1  one-cycle pulse after the last result is stored.
- `result`  output  [0:`output_channel*result_length*result_width*data_width`-1]  packed output map; index 0 is the MSB end.

Behaviour:
- Reset values: `archor_1D`=0, `archor_2D`=0, `win_valid`=0, `busy`=0, `done`=0, `result`=0, row counter r=0, column counter c=0, state=IDLE.
- Reset has priority over everything, including mid-operation. It aborts the scan, discards any partial result and clears `result`.
- IDLE:
  - `conv_en`=1 -> clear `result` to 0, set r=0 and c=0, go to ISSUE.
  - `res_valid` is ignored.
  - `result` holds its last completed map until the next start.
- ISSUE (1 cycle):
  - `win_valid`=1, `archor_2D`=r*`stride`, `archor_1D`=c*`stride`.
  - Go to WAIT.
  - `res_valid` in this cycle is ignored; downstream latency is at least 1 cycle.
- WAIT:
  - Anchors are held stable and `win_valid`=0.
  - On `res_valid`=1, write each channel ch into slot k = r*`result_width` + c.
  - Bit range for that write is [((ch*`result_length*result_width`)+k)*`data_width` +: `data_width`].
  - Channel ch is taken from `res_data` bits [(`output_channel`-1-ch)*`data_width` +: `data_width`].
  - If c < `result_width`-1: c <= c+1, go to ISSUE.
  - Else if r < `result_length`-1: c <= 0, r <= r+1, go to ISSUE.
  - Else go to DONE.
  - No timeout; WAIT holds indefinitely.
- DONE (1 cycle):
  - `done`=1. The final result write is visible on `result` in this same cycle.
  - Go to IDLE.
  - `conv_en` is not sampled in DONE, so there is no restart in DONE.
- `conv_en` asserted while `busy` or in DONE is ignored. If `conv_en` is held high, a new scan starts on the cycle after DONE, i.e. the first IDLE cycle.
- Anchor arithmetic is unsigned and truncated to `data_width`. Counters use `$clog2`-sized registers of at least 1 bit.
- Minimum scan time: 2 cycles per window + 1 DONE cycle.
- `busy` = (state==ISSUE || state==WAIT).

Test Plan:
- Defaults, `conv_en` pulse, `res_valid`/`res_data`=16'h4400 returned 2 cycles after each `win_valid`:
  - anchors (row,col) in order (0,0), (0,1), (1,0), (1,1);
  - `done` pulses once;
  - `result`=64'h4400_4400_4400_4400.
- `result_length`=`result_width`=2, `stride`=2, distinct results 3C00/4000/4200/4400:
  - anchors (0,0), (0,2), (2,0), (2,2);
  - `result`=64'h3C00_4000_4200_4400.
- `output_channel`=2, `res_data`=32'h3C00_4000 for every window:
  - `result`=128'h3C00_3C00_3C00_3C00_4000_4000_4000_4000.
- Protocol edges:
  - `res_valid` pulsed in IDLE and in the ISSUE cycle -> no change to `result` or counters;
  - `conv_en` pulsed while `busy` -> scan unaffected, single `done`.
- Assert `reset` during WAIT of window 2:
  - next cycle all outputs are 0 and state is IDLE;
  - a subsequent `conv_en` scans from anchor (0,0).
- `conv_en` held high continuously -> two back-to-back scans, exactly one IDLE cycle between the `done` pulse and the next `win_valid`.
